// File: rtl/shift_seq.sv
// ---------------------------------------------------------------------------
// shift_seq
//   Multi-cycle shifter/rotator. A request latches an operand, an operation
//   and a step count. The block then moves the operand one bit position per
//   clock until the count reaches zero, and pulses done for one cycle.
//
// Ports
//   clk    in   rising-edge clock
//   reset  in   asynchronous, active-low reset
//   start  in   request strobe; accepted in IDLE or DONE, ignored in SHIFT
//   inA    in   [WIDTH-1:0] operand
//   inC    in   [SHW-1:0]   number of single-bit steps (0..2^SHW-1)
//   op     in   [1:0]       00 lsl, 01 rol, 10 ror, 11 asl with overflow
//   busy   out  high exactly while in SHIFT
//   done   out  high exactly in DONE (one cycle)
//   ans    out  [WIDTH-1:0] working register (intermediate, then final value)
//   ovf    out  sticky overflow for op=11, cleared on acceptance
//
// Handshake: start is a level sampled on the rising edge. A request is
// taken when start=1 and the FSM is in IDLE or DONE; there is no ready
// output, busy=1 marks the cycles in which start is ignored.
// ---------------------------------------------------------------------------
module shift_seq #(
  parameter int WIDTH = 4,
  parameter int SHW   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] inA,
  input  logic [SHW-1:0]   inC,
  input  logic [1:0]       op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] ans,
  output logic             ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [SHW-1:0] CNT_ONE = SHW'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q,  work_d;
  logic [1:0]       op_q,    op_d;
  logic [SHW-1:0]   cnt_q,   cnt_d;
  logic             ovf_q,   ovf_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;

  logic             accept;
  logic [WIDTH-1:0] step_val;
  logic             step_ovf;

  // One single-bit step of the latched operation.
  always_comb begin
    step_val = work_q;
    step_ovf = 1'b0;
    case (op_q)
      2'b00: step_val = {work_q[WIDTH-2:0], 1'b0};
      2'b01: step_val = {work_q[WIDTH-2:0], work_q[WIDTH-1]};
      2'b10: step_val = {work_q[0], work_q[WIDTH-1:1]};
      default: begin
        step_val = {work_q[WIDTH-2:0], 1'b0};
        // Sign changes when the two top bits differ before the step.
        step_ovf = work_q[WIDTH-1] ^ work_q[WIDTH-2];
      end
    endcase
  end

  assign accept = start && (state_q != SHIFT);

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          work_d  = inA;
          op_d    = op;
          cnt_d   = inC;
          ovf_d   = 1'b0;
          state_d = (inC != '0) ? SHIFT : DONE;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        work_d = step_val;
        ovf_d  = ovf_q | step_ovf;
        cnt_d  = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Status flags are registered copies of the next state so they line up
    // with state_q without any input-to-output path.
    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      work_q  <= '0;
      op_q    <= 2'b00;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign ans  = work_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_shift_seq.sv
// ---------------------------------------------------------------------------
// tb_shift_seq
//   Directed and random bench for shift_seq (WIDTH=4, SHW=2). Expected
//   {ovf, ans} results are queued when a request is driven and compared
//   when done is observed. Inputs change and outputs are sampled on the
//   falling clock edge.
// ---------------------------------------------------------------------------
module tb_shift_seq;

  localparam int WIDTH = 4;
  localparam int SHW   = 2;

  logic             clk;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] inA;
  logic [SHW-1:0]   inC;
  logic [1:0]       op;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] ans;
  logic             ovf;

  logic [WIDTH:0] exp_q[$];
  int checks;
  int failures;

  shift_seq #(.WIDTH(WIDTH), .SHW(SHW)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .inA   (inA),
    .inC   (inC),
    .op    (op),
    .busy  (busy),
    .done  (done),
    .ans   (ans),
    .ovf   (ovf)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: {ovf, ans} after n single-bit steps.
  function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] a, input logic [1:0] o, input int n);
    logic [WIDTH-1:0] w;
    logic v;
    w = a;
    v = 1'b0;
    for (int i = 0; i < n; i++) begin
      case (o)
        2'b00: w = w << 1;
        2'b01: w = {w[WIDTH-2:0], w[WIDTH-1]};
        2'b10: w = {w[0], w[WIDTH-1:1]};
        default: begin
          if (w[WIDTH-1] != w[WIDTH-2]) v = 1'b1;
          w = w << 1;
        end
      endcase
    end
    return {v, w};
  endfunction

  // driver: call on a falling edge; the next rising edge should accept.
  task automatic issue(input logic [WIDTH-1:0] a, input logic [1:0] o,
                       input logic [SHW-1:0] c, input logic [WIDTH:0] exp);
    start = 1'b1;
    inA   = a;
    op    = o;
    inC   = c;
    exp_q.push_back(exp);
  endtask

  // Waits for the accepting edge, follows the operation to done and checks
  // busy, intermediate ans, latency and the final result. Returns on the
  // falling edge where done is high. With poke set, start is raised during
  // SHIFT with different operands, which must be ignored.
  task automatic wait_done(input logic [WIDTH-1:0] a, input logic [1:0] o,
                           input int c, input bit poke);
    int edges;
    bit seen;
    logic [WIDTH:0] mid;
    logic [WIDTH:0] got;
    logic [WIDTH:0] exp;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    inA   = WIDTH'($urandom_range(0, 15));
    op    = 2'($urandom_range(0, 3));
    inC   = SHW'($urandom_range(0, 3));
    edges = 1;
    seen  = 1'b0;
    while (edges <= 10) begin
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      mid = model(a, o, edges - 1);
      check("busy_in_shift", busy, 1);
      check("ans_step", ans, mid[WIDTH-1:0]);
      if (poke && edges == 1) begin
        start = 1'b1;
        inA   = ~a;
        op    = ~o;
        inC   = 2'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      edges++;
    end
    start = 1'b0;
    check("done_seen", seen, 1);
    if (seen) begin
      check("latency", edges, c + 1);
      check("busy_in_done", busy, 0);
      got = {ovf, ans};
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        check("result", got, exp);
      end else begin
        check("queue_nonempty", 0, 1);
      end
    end
  endtask

  task automatic idle_check();
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("busy_idle", busy, 0);
  endtask

  initial begin
    logic [WIDTH-1:0] ra;
    logic [1:0]       ro;
    logic [SHW-1:0]   rc;
    checks   = 0;
    failures = 0;
    start    = 1'b0;
    inA      = '0;
    inC      = '0;
    op       = 2'b00;
    reset    = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_ans", ans, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ovf", ovf, 0);
    reset = 1'b1;

    // lsl 0011 by 2 -> 1100, issued on the first edge after reset release
    issue(4'b0011, 2'b00, 2'd2, {1'b0, 4'b1100});
    wait_done(4'b0011, 2'b00, 2, 1'b0);
    idle_check();

    // rol 1001 by 1 -> 0011
    @(negedge clk);
    issue(4'b1001, 2'b01, 2'd1, {1'b0, 4'b0011});
    wait_done(4'b1001, 2'b01, 1, 1'b0);
    idle_check();

    // ror 0001 by 3 -> 1000, 0100, 0010
    @(negedge clk);
    issue(4'b0001, 2'b10, 2'd3, {1'b0, 4'b0010});
    wait_done(4'b0001, 2'b10, 3, 1'b0);
    idle_check();

    // asl with overflow, then without
    @(negedge clk);
    issue(4'b0011, 2'b11, 2'd2, {1'b1, 4'b1100});
    wait_done(4'b0011, 2'b11, 2, 1'b0);
    idle_check();
    check("ovf_hold", ovf, 1);
    @(negedge clk);
    issue(4'b0001, 2'b11, 2'd1, {1'b0, 4'b0010});
    wait_done(4'b0001, 2'b11, 1, 1'b0);
    idle_check();

    // zero-step requests
    @(negedge clk);
    issue(4'b1010, 2'b01, 2'd0, {1'b0, 4'b1010});
    wait_done(4'b1010, 2'b01, 0, 1'b0);
    idle_check();
    @(negedge clk);
    issue(4'b1010, 2'b11, 2'd0, {1'b0, 4'b1010});
    wait_done(4'b1010, 2'b11, 0, 1'b0);
    idle_check();

    // start during SHIFT is ignored
    @(negedge clk);
    issue(4'b0110, 2'b01, 2'd3, {1'b0, 4'b0011});
    wait_done(4'b0110, 2'b01, 3, 1'b1);
    idle_check();

    // back-to-back: new request accepted on the DONE edge
    @(negedge clk);
    issue(4'b0101, 2'b00, 2'd1, {1'b0, 4'b1010});
    wait_done(4'b0101, 2'b00, 1, 1'b0);
    issue(4'b1000, 2'b10, 2'd2, {1'b0, 4'b0010});
    wait_done(4'b1000, 2'b10, 2, 1'b0);
    idle_check();

    // asynchronous reset mid-SHIFT aborts with no done
    @(negedge clk);
    issue(4'b0011, 2'b11, 2'd3, {1'b1, 4'b1000});
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("pre_rst_busy", busy, 1);
    check("pre_rst_ans", ans, 4'b0110);
    #2 reset = 1'b0;
    #1;
    check("async_ans", ans, 0);
    check("async_busy", busy, 0);
    check("async_done", done, 0);
    check("async_ovf", ovf, 0);
    void'(exp_q.pop_front());
    @(negedge clk);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("no_done_after_abort", done, 0);
    end
    issue(4'b0011, 2'b11, 2'd3, {1'b1, 4'b1000});
    wait_done(4'b0011, 2'b11, 3, 1'b0);
    idle_check();

    // random operations against the reference
    for (int i = 0; i < 8; i++) begin
      ra = WIDTH'($urandom_range(0, 15));
      ro = 2'($urandom_range(0, 3));
      rc = SHW'($urandom_range(0, 3));
      @(negedge clk);
      issue(ra, ro, rc, model(ra, ro, int'(rc)));
      wait_done(ra, ro, int'(rc), 1'b0);
      idle_check();
    end

    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_seq.md
SHIFT_SEQ -- requirements
Module: shift_seq

Interface
REQ-001 Parameter WIDTH, default 4: data width of inA and ans.
REQ-002 Parameter SHW, default 2: width of the shift-amount input inC.
REQ-003 The block SHALL have exactly one clock domain and an asynchronous, active-low reset, with these ports in this order:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request strobe, sampled on the rising clk edge.
- inA  input  WIDTH  operand.
- inC  input  SHW  shift amount, range 0..2^SHW-1.
- op  input  2  operation select.
- busy  output  1  high while shifting.
- done  output  1  one-cycle completion pulse.
- ans  output  WIDTH  result register.
- ovf  output  1  overflow flag for op=11.

Function
REQ-004 Operations, one bit position per step:
- 00 = logical left shift, zero-fill.
- 01 = rotate left.
- 10 = rotate right.
- 11 = arithmetic left shift, zero-fill, with overflow detection.
REQ-005 The FSM SHALL have three states: IDLE, SHIFT, DONE.
REQ-006 A request SHALL be accepted at a rising edge where start=1 and state is IDLE or DONE; start in SHIFT SHALL be ignored.
REQ-007 On acceptance the block SHALL latch inA into the working register, op into the op register, and inC into a down-counter, and SHALL clear ovf.
REQ-008 After acceptance the next state SHALL be SHIFT if inC≠0, else DONE.
REQ-009 In SHIFT, each rising edge SHALL apply one single-bit step of the latched op and decrement the counter.
REQ-010 When a step brings the counter to 0, the FSM SHALL move to DONE on that same edge.
REQ-011 Latency: done SHALL assert exactly inC+1 rising edges after the accepting edge.
- inC=0: one edge.
- inC=3: four edges.
REQ-012 busy SHALL be 1 exactly in SHIFT and 0 in IDLE and DONE.
REQ-013 done SHALL be 1 exactly in DONE, for one cycle.
REQ-014 DONE SHALL go to IDLE unless a new start is accepted on that edge, which gives back-to-back operation with no idle cycle.
REQ-015 ans SHALL always equal the working register.
- During SHIFT it shows intermediate values.
- From DONE onward it holds the final result until the next acceptance.
REQ-016 For op=11, ovf SHALL be set (sticky) at any step where bit[WIDTH-1] differs from bit[WIDTH-2] before the step.
REQ-017 For ops 00, 01 and 10, ovf SHALL stay 0.
REQ-018 ovf SHALL hold its value with ans until the next acceptance.
REQ-019 Changes to inA, inC or op after acceptance SHALL NOT affect the operation in flight.
REQ-020 All state SHALL be registered; outputs SHALL have no combinational path from inputs.

Reset
REQ-021 While reset=0, the block SHALL immediately and asynchronously go to IDLE with ans=0, ovf=0, busy=0, done=0, and counter=0.
REQ-022 Assertion of reset in SHIFT or DONE SHALL abort the operation with no done pulse.
REQ-023 The first edge after reset deasserts SHALL accept start normally.

Verification
REQ-024 The bench SHALL cover these directed scenarios (WIDTH=4, SHW=2):
- inA=0011, op=00, inC=2, start one cycle -> busy=1 for 2 cycles, then done=1 with ans=1100, ovf=0.
- inA=1001, op=01, inC=1 -> done 2 edges after start, ans=0011.
- inA=0001, op=10, inC=3 -> ans sequence 1000, 0100, 0010, then done=1 with ans=0010.
- inA=0011, op=11, inC=2 -> ans=1100, ovf=1; inA=0001, op=11, inC=1 -> ans=0010, ovf=0.
- inC=0, inA=1010, any op -> done=1 one edge after start, ans=1010, busy never 1.
- Start asserted during SHIFT -> ignored.
- Start during DONE -> new operation accepted back-to-back.
- reset=0 mid-SHIFT -> outputs zero immediately, no done, next start works.
